// File: rtl/digdug_vram_arbiter.sv
// Time-division foreground VRAM arbiter: one 8-phase frame per pixel clock. Video reads
// in phases 0/1; CPUs are served round-robin in grant phases 2/4/6 and complete one phase later.
module digdug_vram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          CLK48M,
  input  logic          RESET,
  output logic [2:0]    PHASE,
  input  logic [AW-1:0] VSAD,
  output logic [DW-1:0] VSDT,
  input  logic          C0_REQ,
  input  logic          C0_WE,
  input  logic [AW-1:0] C0_AD,
  input  logic [DW-1:0] C0_DI,
  output logic [DW-1:0] C0_DO,
  output logic          C0_ACK,
  input  logic          C1_REQ,
  input  logic          C1_WE,
  input  logic [AW-1:0] C1_AD,
  input  logic [DW-1:0] C1_DI,
  output logic [DW-1:0] C1_DO,
  output logic          C1_ACK,
  input  logic          C2_REQ,
  input  logic          C2_WE,
  input  logic [AW-1:0] C2_AD,
  input  logic [DW-1:0] C2_DI,
  output logic [DW-1:0] C2_DO,
  output logic          C2_ACK,
  output logic [AW-1:0] RAMAD,
  output logic          RAMWE,
  output logic [DW-1:0] RAMDI,
  input  logic [DW-1:0] RAMDO
);

  logic [2:0]    phase_q;
  logic [2:0]    phase_nx;
  logic          grant_slot;
  logic [1:0]    last_q;
  logic [1:0]    win;
  logic [1:0]    cand;
  logic          win_valid;
  logic          pend_q;
  logic          pend_we_q;
  logic [1:0]    pend_id_q;
  logic [2:0]    ack_q;
  logic [DW-1:0] vsdt_q;
  logic [AW-1:0] ramad_q;
  logic          ramwe_q;
  logic [DW-1:0] ramdi_q;
  logic [DW-1:0] do_q [3];
  logic [2:0]    req;
  logic [2:0]    we;
  logic [AW-1:0] cpu_ad [3];
  logic [DW-1:0] cpu_di [3];

  assign req       = {C2_REQ, C1_REQ, C0_REQ};
  assign we        = {C2_WE, C1_WE, C0_WE};
  assign cpu_ad[0] = C0_AD;
  assign cpu_ad[1] = C1_AD;
  assign cpu_ad[2] = C2_AD;
  assign cpu_di[0] = C0_DI;
  assign cpu_di[1] = C1_DI;
  assign cpu_di[2] = C2_DI;

  // Outputs are registered one edge ahead, so slot decisions key off the phase being entered.
  assign phase_nx   = phase_q + 3'd1;
  assign grant_slot = ~phase_nx[0] & (phase_nx != 3'd0);

  // Round-robin scan LAST+1, LAST+2, LAST+3 (mod 3); first requester found wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    win_valid = 1'b0;
    win       = last_q;
    cand      = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      phase_q   <= 3'd0;
      last_q    <= 2'd2;
      pend_q    <= 1'b0;
      pend_we_q <= 1'b0;
      pend_id_q <= 2'd0;
      ack_q     <= 3'b000;
      vsdt_q    <= '0;
      ramad_q   <= '0;
      ramwe_q   <= 1'b0;
      ramdi_q   <= '0;
      for (int n = 0; n < 3; n++) do_q[n] <= '0;
    end else begin
      phase_q <= phase_nx;
      ramwe_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 3'b000;
      if (phase_q == 3'd1) vsdt_q <= RAMDO;
      // RAMDO is valid during the ACK cycle; pend_id_q still names that access here.
      if (ack_q != 3'b000 && !pend_we_q) do_q[pend_id_q] <= RAMDO;
      if (pend_q) ack_q <= 3'b001 << pend_id_q;
      if (phase_nx == 3'd0) begin
        ramad_q <= VSAD;
      end else if (grant_slot && win_valid) begin
        ramad_q   <= cpu_ad[win];
        ramwe_q   <= we[win];
        if (we[win]) ramdi_q <= cpu_di[win];
        last_q    <= win;
        pend_q    <= 1'b1;
        pend_id_q <= win;
        pend_we_q <= we[win];
      end
    end
  end

  assign PHASE  = phase_q;
  assign VSDT   = vsdt_q;
  assign RAMAD  = ramad_q;
  assign RAMDI  = ramdi_q;
  // Gated so a reset landing on a write slot aborts the write at the RAM's sampling edge.
  assign RAMWE  = ramwe_q & ~RESET;
  assign C0_ACK = ack_q[0];
  assign C1_ACK = ack_q[1];
  assign C2_ACK = ack_q[2];
  assign C0_DO  = do_q[0];
  assign C1_DO  = do_q[1];
  assign C2_DO  = do_q[2];

endmodule
